// File: rtl/mil_rt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mil_rt_pkg
// Brief   : Shared types and constants for the MIL-STD-1553 remote terminal.
// Revision: 1.0 - initial release
// ============================================================================
package mil_rt_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_DATA   = 3'd1,
        GAP       = 3'd2,
        TX_STATUS = 3'd3,
        TX_DATA   = 3'd4
    } rt_state_t;

    typedef struct packed {
        logic [4:0] rt;
        logic       tr;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_word_t;

    localparam logic [4:0] BROADCAST_ADDR = 5'd31;
    localparam logic [4:0] MC_TX_STATUS   = 5'd2;
    localparam logic [4:0] MODE_SA0       = 5'd0;
    localparam logic [4:0] MODE_SA31      = 5'd31;

    // A word count field of zero means a full 32-word message.
    function automatic logic [5:0] wcToCount(input logic [4:0] wc);
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mil_rt_mem.sv
`default_nettype none
// ============================================================================
// Module  : mil_rt_mem
// Brief   : 1024x16 true dual-port buffer, port A = RT, port B = host.
// Revision: 1.0 - initial release
// ============================================================================
module mil_rt_mem (
    input  logic        clk,
    input  logic        nRst,
    input  logic        aWe,
    input  logic [9:0]  aAddr,
    input  logic [15:0] aWrData,
    output logic [15:0] aRdData,
    input  logic        bWe,
    input  logic [9:0]  bAddr,
    input  logic [15:0] bWrData,
    output logic [15:0] bRdData
);
    logic [15:0] r_mem [0:1023];
    logic [15:0] r_aRd;
    logic [15:0] r_bRd;

    // On a same-address collision the RT write takes priority over the host.
    always_ff @(posedge clk) begin
        if (aWe) begin
            r_mem[aAddr] <= aWrData;
        end
        if (bWe && !(aWe && (aAddr == bAddr))) begin
            r_mem[bAddr] <= bWrData;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_aRd <= 16'd0;
            r_bRd <= 16'd0;
        end else begin
            r_aRd <= r_mem[aAddr];
            r_bRd <= r_mem[bAddr];
        end
    end

    assign aRdData = r_aRd;
    assign bRdData = r_bRd;

endmodule
`default_nettype wire

// File: rtl/mil_remote_terminal.sv
`default_nettype none
// ============================================================================
// Module  : mil_remote_terminal
// Brief   : MIL-STD-1553 remote terminal responder with 32x32 word buffer.
// Revision: 1.0 - initial release
// ============================================================================
module mil_remote_terminal
    import mil_rt_pkg::*;
#(
    parameter int RESP_DELAY   = 40,
    parameter int WORD_TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [4:0]  rtAddr,
    input  logic        rxValid,
    input  logic [15:0] rxData,
    input  logic        rxIsCmd,
    input  logic        rxError,
    output logic        txRequest,
    output logic [15:0] txData,
    output logic        txIsCmd,
    input  logic        txDone,
    input  logic [9:0]  hostAddr,
    input  logic [15:0] hostWrData,
    input  logic        hostWe,
    output logic [15:0] hostRdData,
    output logic        msgDone,
    output logic [4:0]  msgSubaddr,
    output logic        msgIsRx,
    output logic        msgError
);
    localparam int TMR_MAX = (RESP_DELAY > WORD_TIMEOUT) ? RESP_DELAY : WORD_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    rt_state_t r_state, w_stateNext;
    logic [4:0]       r_sa, w_sa, r_wc, w_wc, r_msgSa, w_msgSa;
    logic [5:0]       r_idx, w_idx;
    logic [TMR_W-1:0] r_timer, w_timer;
    logic r_tr, w_tr, r_isMode, w_isMode, r_bcast, w_bcast;
    logic r_me, w_me, r_bcr, w_bcr, r_statusMe, w_statusMe;
    logic r_msgDone, w_msgDone, r_msgIsRx, w_msgIsRx, r_msgErr, w_msgErr;
    logic w_memWe, w_cmdAccept, w_cmdIsMode;
    logic [9:0]  w_memAddr;
    logic [15:0] w_memRd;
    cmd_word_t   w_cmd;

    assign w_cmd       = cmd_word_t'(rxData);
    assign w_cmdAccept = rxValid && rxIsCmd && !rxError &&
                         ((w_cmd.rt == rtAddr) || (w_cmd.rt == BROADCAST_ADDR));
    assign w_cmdIsMode = (w_cmd.sa == MODE_SA0) || (w_cmd.sa == MODE_SA31);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_sa <= 5'd0; r_wc <= 5'd0; r_idx <= 6'd0; r_timer <= '0;
            r_tr <= 1'b0; r_isMode <= 1'b0; r_bcast <= 1'b0;
            r_me <= 1'b0; r_bcr <= 1'b0; r_statusMe <= 1'b0;
            r_msgDone <= 1'b0; r_msgSa <= 5'd0; r_msgIsRx <= 1'b0; r_msgErr <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_sa <= w_sa; r_wc <= w_wc; r_idx <= w_idx; r_timer <= w_timer;
            r_tr <= w_tr; r_isMode <= w_isMode; r_bcast <= w_bcast;
            r_me <= w_me; r_bcr <= w_bcr; r_statusMe <= w_statusMe;
            r_msgDone <= w_msgDone; r_msgSa <= w_msgSa; r_msgIsRx <= w_msgIsRx; r_msgErr <= w_msgErr;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_sa = r_sa; w_wc = r_wc; w_idx = r_idx; w_timer = r_timer;
        w_tr = r_tr; w_isMode = r_isMode; w_bcast = r_bcast;
        w_me = r_me; w_bcr = r_bcr; w_statusMe = r_statusMe;
        w_msgDone = 1'b0; w_msgSa = r_msgSa; w_msgIsRx = r_msgIsRx; w_msgErr = r_msgErr;
        w_memWe = 1'b0;

        case (r_state)
            IDLE: ;
            RX_DATA: begin
                if (rxValid && rxError) begin
                    w_me        = 1'b1;
                    w_stateNext = IDLE;
                end else if (rxValid && rxIsCmd) begin
                    w_stateNext = IDLE;
                end else if (rxValid) begin
                    w_memWe = 1'b1;
                    w_idx   = r_idx + 6'd1;
                    w_timer = '0;
                    if (w_idx == wcToCount(r_wc)) begin
                        if (r_bcast) begin
                            w_stateNext = IDLE;
                            w_bcr       = 1'b1;
                            w_msgDone   = 1'b1;
                            w_msgSa     = r_sa;
                            w_msgIsRx   = 1'b1;
                            w_msgErr    = r_me;
                        end else begin
                            w_stateNext = GAP;
                        end
                    end
                end else if (r_timer == TMR_W'(WORD_TIMEOUT - 1)) begin
                    w_me        = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            GAP: begin
                if (r_timer == TMR_W'(RESP_DELAY - 1)) begin
                    w_stateNext = TX_STATUS;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            TX_STATUS: begin
                if (txDone) begin
                    w_statusMe = r_me;
                    if (!(r_isMode && (r_wc == MC_TX_STATUS))) begin
                        w_me  = 1'b0;
                        w_bcr = 1'b0;
                    end
                    if (!r_isMode && r_tr) begin
                        w_stateNext = TX_DATA;
                    end else begin
                        w_stateNext = IDLE;
                        w_msgDone   = 1'b1;
                        w_msgSa     = r_sa;
                        w_msgIsRx   = !r_tr;
                        w_msgErr    = r_me;
                    end
                end
            end
            TX_DATA: begin
                if (txDone) begin
                    w_idx = r_idx + 6'd1;
                    if (w_idx == wcToCount(r_wc)) begin
                        w_stateNext = IDLE;
                        w_msgDone   = 1'b1;
                        w_msgSa     = r_sa;
                        w_msgIsRx   = 1'b0;
                        w_msgErr    = r_statusMe;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase

        // A fresh accepted command overrides whatever the current state decided.
        if (w_cmdAccept) begin
            w_sa = w_cmd.sa; w_wc = w_cmd.wc; w_tr = w_cmd.tr;
            w_isMode  = w_cmdIsMode;
            w_bcast   = (w_cmd.rt == BROADCAST_ADDR);
            w_idx     = 6'd0;
            w_timer   = '0;
            w_memWe   = 1'b0;
            w_msgDone = 1'b0;
            w_stateNext = IDLE;
            if (!w_cmdIsMode) begin
                if (!w_cmd.tr) begin
                    w_stateNext = RX_DATA;
                end else if (!w_bcast) begin
                    w_stateNext = GAP;
                end
            end else if (!w_bcast) begin
                w_stateNext = GAP;
                if (!w_cmd.tr || w_cmd.wc[4]) begin
                    w_me = 1'b1;
                end
            end
        end
    end

    // Transmit reads run on the next index so the following word is ready one cycle after txDone.
    assign w_memAddr = (r_state == RX_DATA) ? {r_sa, r_idx[4:0]} : {r_sa, w_idx[4:0]};

    mil_rt_mem u_mem (
        .clk     (clk),
        .nRst    (nRst),
        .aWe     (w_memWe),
        .aAddr   (w_memAddr),
        .aWrData (rxData),
        .aRdData (w_memRd),
        .bWe     (hostWe),
        .bAddr   (hostAddr),
        .bWrData (hostWrData),
        .bRdData (hostRdData)
    );

    assign txRequest  = (r_state == TX_STATUS) || (r_state == TX_DATA);
    assign txIsCmd    = (r_state == TX_STATUS);
    // Status word: ME at bit 10, broadcast-received at bit 4.
    assign txData     = (r_state == TX_STATUS) ? {rtAddr, r_me, 5'b0, r_bcr, 4'b0} :
                        (r_state == TX_DATA)   ? w_memRd : 16'd0;
    assign msgDone    = r_msgDone;
    assign msgSubaddr = r_msgSa;
    assign msgIsRx    = r_msgIsRx;
    assign msgError   = r_msgErr;

endmodule
`default_nettype wire

// File: tb/tb_mil_remote_terminal.sv
`default_nettype none
// ============================================================================
// Module  : tb_mil_remote_terminal
// Brief   : Directed scoreboard bench for the MIL-STD-1553 remote terminal.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mil_remote_terminal;
    localparam int RESP_DELAY   = 40;
    localparam int WORD_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [4:0]  rtAddr = 5'd5;
    logic        rxValid = 1'b0, rxIsCmd = 1'b0, rxError = 1'b0;
    logic [15:0] rxData = 16'd0;
    logic        txRequest, txIsCmd;
    logic [15:0] txData;
    logic        txDone = 1'b0;
    logic [9:0]  hostAddr = 10'd0;
    logic [15:0] hostWrData = 16'd0;
    logic        hostWe = 1'b0;
    logic [15:0] hostRdData;
    logic        msgDone, msgIsRx, msgError;
    logic [4:0]  msgSubaddr;

    typedef struct packed {
        logic        isCmd;
        logic [15:0] data;
    } txExp_t;
    txExp_t sb[$];

    int errors = 0;
    int checks = 0;
    int msgCnt = 0;
    int txReqCnt = 0;

    always #5 clk = ~clk;

    mil_remote_terminal #(.RESP_DELAY(RESP_DELAY), .WORD_TIMEOUT(WORD_TIMEOUT)) dut (
        .clk(clk), .nRst(nRst), .rtAddr(rtAddr),
        .rxValid(rxValid), .rxData(rxData), .rxIsCmd(rxIsCmd), .rxError(rxError),
        .txRequest(txRequest), .txData(txData), .txIsCmd(txIsCmd), .txDone(txDone),
        .hostAddr(hostAddr), .hostWrData(hostWrData), .hostWe(hostWe), .hostRdData(hostRdData),
        .msgDone(msgDone), .msgSubaddr(msgSubaddr), .msgIsRx(msgIsRx), .msgError(msgError)
    );

    always @(posedge clk) begin
        if (msgDone)   msgCnt   <= msgCnt + 1;
        if (txRequest) txReqCnt <= txReqCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendWord(input logic [15:0] d, input logic isCmd, input logic err);
        @(negedge clk);
        rxValid = 1'b1; rxData = d; rxIsCmd = isCmd; rxError = err;
        @(negedge clk);
        rxValid = 1'b0; rxIsCmd = 1'b0; rxError = 1'b0;
    endtask

    task automatic expectTx(input logic isCmd, input logic [15:0] d);
        txExp_t e;
        e.isCmd = isCmd;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic hostWrite(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        hostAddr = a; hostWrData = d; hostWe = 1'b1;
        @(negedge clk);
        hostWe = 1'b0;
    endtask

    task automatic hostCheck(input string tag, input logic [9:0] a, input logic [15:0] exp);
        @(negedge clk);
        hostAddr = a;
        @(posedge clk);
        #1 check(tag, hostRdData, exp);
    endtask

    // Pops one scoreboard entry per transmitted word and acknowledges it.
    task automatic serviceTx(input int n);
        txExp_t e;
        bit found;
        for (int i = 0; i < n; i++) begin
            found = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(posedge clk);
                #1;
                if (txRequest) begin
                    found = 1'b1;
                    break;
                end
            end
            e = sb.pop_front();
            if (!found) begin
                check("tx_timeout", 32'd0, 32'd1);
            end else begin
                check("txIsCmd", txIsCmd, e.isCmd);
                check("txData", txData, e.data);
                repeat (2) @(posedge clk);
                #1 check("txHold", {txRequest, txData}, {1'b1, e.data});
                @(negedge clk) txDone = 1'b1;
                @(negedge clk) txDone = 1'b0;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        int n, m0, t0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txRequest", txRequest, 1'b0);
        check("rst_txData", txData, 16'h0000);
        check("rst_msg", {msgDone, msgSubaddr, msgIsRx, msgError}, 8'h00);
        check("rst_hostRd", hostRdData, 16'h0000);
        nRst = 1'b1;
        settle();

        // 1: receive 3 words, measure response gap
        m0 = msgCnt;
        expectTx(1'b1, 16'h2800);
        sendWord(16'h2843, 1'b1, 1'b0);
        sendWord(16'h1111, 1'b0, 1'b0);
        sendWord(16'h2222, 1'b0, 1'b0);
        sendWord(16'h3333, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1 n++;
            if (txRequest) break;
        end
        check("t1_gap", n, RESP_DELAY);
        serviceTx(1);
        settle();
        check("t1_msgCnt", msgCnt - m0, 1);
        check("t1_msgInfo", {msgSubaddr, msgIsRx, msgError}, {5'd2, 1'b1, 1'b0});
        hostCheck("t1_mem0", {5'd2, 5'd0}, 16'h1111);
        hostCheck("t1_mem1", {5'd2, 5'd1}, 16'h2222);
        hostCheck("t1_mem2", {5'd2, 5'd2}, 16'h3333);

        // 2: transmit 32 words
        for (int i = 0; i < 32; i++) hostWrite({5'd4, i[4:0]}, 16'(i));
        m0 = msgCnt;
        expectTx(1'b1, 16'h2800);
        for (int i = 0; i < 32; i++) expectTx(1'b0, 16'(i));
        sendWord(16'h2C80, 1'b1, 1'b0);
        serviceTx(33);
        settle();
        check("t2_msgCnt", msgCnt - m0, 1);
        check("t2_msgInfo", {msgSubaddr, msgIsRx}, {5'd4, 1'b0});
        check("t2_idle", txRequest, 1'b0);

        // 3: broadcast receive, then transmit-status mode code
        m0 = msgCnt; t0 = txReqCnt;
        sendWord(16'hF841, 1'b1, 1'b0);
        sendWord(16'hABCD, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check("t3_noTx", txReqCnt - t0, 0);
        check("t3_msgCnt", msgCnt - m0, 1);
        check("t3_msgInfo", {msgSubaddr, msgIsRx}, {5'd2, 1'b1});
        hostCheck("t3_mem", {5'd2, 5'd0}, 16'hABCD);
        expectTx(1'b1, 16'h2810);
        sendWord(16'h2C02, 1'b1, 1'b0);
        serviceTx(1);
        // BCR survives mode code 2; an ordinary receive reports and clears it
        expectTx(1'b1, 16'h2810);
        sendWord(16'h2861, 1'b1, 1'b0);
        sendWord(16'h0F0F, 1'b0, 1'b0);
        serviceTx(1);
        settle();

        // 4: errored data word
        m0 = msgCnt; t0 = txReqCnt;
        sendWord(16'h2842, 1'b1, 1'b0);
        sendWord(16'h4444, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("t4_noTx", txReqCnt - t0, 0);
        check("t4_noMsg", msgCnt - m0, 0);
        expectTx(1'b1, 16'h2C00);
        sendWord(16'h2C02, 1'b1, 1'b0);
        serviceTx(1);
        settle();
        check("t4_msgError", msgError, 1'b1);
        expectTx(1'b1, 16'h2C00);
        sendWord(16'h2861, 1'b1, 1'b0);
        sendWord(16'h0F0F, 1'b0, 1'b0);
        serviceTx(1);
        settle();

        // 5a: inter-word timeout
        m0 = msgCnt; t0 = txReqCnt;
        sendWord(16'h2842, 1'b1, 1'b0);
        sendWord(16'h5151, 1'b0, 1'b0);
        repeat (WORD_TIMEOUT + 50) @(negedge clk);
        check("t5_noTx", txReqCnt - t0, 0);
        check("t5_noMsg", msgCnt - m0, 0);
        expectTx(1'b1, 16'h2C00);
        sendWord(16'h2C02, 1'b1, 1'b0);
        serviceTx(1);
        expectTx(1'b1, 16'h2C00);
        sendWord(16'h2861, 1'b1, 1'b0);
        sendWord(16'h0F0F, 1'b0, 1'b0);
        serviceTx(1);
        settle();

        // 5b: new command mid-receive
        m0 = msgCnt;
        expectTx(1'b1, 16'h2800);
        sendWord(16'h2843, 1'b1, 1'b0);
        sendWord(16'h7777, 1'b0, 1'b0);
        sendWord(16'h2861, 1'b1, 1'b0);
        sendWord(16'h5555, 1'b0, 1'b0);
        serviceTx(1);
        settle();
        check("t5b_msgCnt", msgCnt - m0, 1);
        check("t5b_msgSa", msgSubaddr, 5'd3);
        hostCheck("t5b_mem", {5'd3, 5'd0}, 16'h5555);

        // 6: reset during TX_DATA
        expectTx(1'b1, 16'h2800);
        expectTx(1'b0, 16'h0000);
        sendWord(16'h2C80, 1'b1, 1'b0);
        serviceTx(2);
        @(negedge clk);
        check("t6_word1", {txRequest, txIsCmd, txData}, {1'b1, 1'b0, 16'h0001});
        nRst = 1'b0;
        #1 check("t6_rstDrop", txRequest, 1'b0);
        check("t6_rstMsg", msgDone, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        settle();
        check("t6_idle", txRequest, 1'b0);
        expectTx(1'b1, 16'h2800);
        sendWord(16'h2861, 1'b1, 1'b0);
        sendWord(16'h6666, 1'b0, 1'b0);
        serviceTx(1);
        settle();
        check("t6_msgSa", msgSubaddr, 5'd3);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
